// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one ROM read port by two requesters, with a read watchdog.
// Latency: rom_start 1 cycle after grant, doneN 1 cycle after rom_done or after TIMEOUT_CYCLES in WAIT; optional ROM_CACHE_EN one-entry hit cache.
// Backpressure: requests are held in IDLE while rom_ready=0 (a cache hit does not need rom_ready).
module rom_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  input  logic                  cache_flush,
  input  logic                  rom_ready,
  output logic                  rom_start,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic                  rom_done,
  input  logic [DATA_WIDTH-1:0] rom_data
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q, prio_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  err_q, err_d;
  logic                  rom_start_q, rom_start_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  any_req, sel, hit, timed_out;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] hit_data;

  assign any_req   = req0 | req1;
  assign sel       = (req0 & req1) ? prio_q : req1;
  assign sel_addr  = sel ? addr1 : addr0;
  assign timed_out = (cnt_q == CNT_MAX);

`ifdef ROM_CACHE_EN
  logic                  cvalid_q, cvalid_d;
  logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
  logic [DATA_WIDTH-1:0] cdata_q, cdata_d;

  assign hit      = cvalid_q && (caddr_q == sel_addr);
  assign hit_data = cdata_q;

  // Flush is applied last so it beats a fill in the same cycle.
  always_comb begin
    cvalid_d = cvalid_q;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
    if (state_q == WAIT) begin
      if (rom_done) begin
        cvalid_d = 1'b1;
        caddr_d  = rom_address_q;
        cdata_d  = rom_data;
      end else if (timed_out) begin
        cvalid_d = 1'b0;
      end
    end
    if (cache_flush) cvalid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cvalid_q <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= '0;
    end else begin
      cvalid_q <= cvalid_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
    end
  end
`else
  logic unused_cache_flush;
  assign unused_cache_flush = cache_flush;
  assign hit                = 1'b0;
  assign hit_data           = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      prio_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      err_q         <= 1'b0;
      rom_start_q   <= 1'b0;
      rdata_q       <= '0;
      rom_address_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      prio_q        <= prio_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      err_q         <= err_d;
      rom_start_q   <= rom_start_d;
      rdata_q       <= rdata_d;
      rom_address_q <= rom_address_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req && hit)            state_d = RESP;
        else if (any_req && rom_ready) state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (rom_done || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done/rdata/err are loaded on the edge entering RESP so they appear for that one cycle.
  always_comb begin
    owner_d       = owner_q;
    prio_d        = prio_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    err_d         = err_q;
    rom_start_d   = 1'b0;
    rdata_d       = rdata_q;
    rom_address_d = rom_address_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req && hit) begin
          owner_d = sel;
          rdata_d = hit_data;
          err_d   = 1'b0;
          if (sel) done1_d = 1'b1;
          else     done0_d = 1'b1;
        end else if (any_req && rom_ready) begin
          owner_d       = sel;
          rom_start_d   = 1'b1;
          rom_address_d = sel_addr;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        if (rom_done || timed_out) begin
          rdata_d = rom_done ? rom_data : '0;
          err_d   = ~rom_done;
          if (owner_q) done1_d = 1'b1;
          else         done0_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    prio_d = ~owner_q;
      default: ;
    endcase
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign rom_start   = rom_start_q;
  assign rom_address = rom_address_q;
endmodule
